// File: rtl/flit_checksum_unit_pkg.sv
// Shared types, default field widths and helpers for the NoC flit checksum engine.
package flit_checksum_unit_pkg;

    localparam int DEF_HEADER_W  = 16;
    localparam int DEF_PAYLOAD_W = 40;
    localparam int DEF_CSUM_W    = 8;
    localparam int DEF_DATA_W    = DEF_HEADER_W + DEF_PAYLOAD_W;
    localparam int DEF_FLIT_W    = DEF_DATA_W + DEF_CSUM_W;

    typedef logic [DEF_FLIT_W-1:0] flit_t;
    typedef logic [DEF_CSUM_W-1:0] checksum_t;

    typedef enum logic { CSUM_XOR = 1'b0, CSUM_ONES = 1'b1 } csum_algo_e;
    typedef enum logic { MODE_GEN = 1'b0, MODE_CHK = 1'b1 } mode_e;
    typedef enum logic [1:0] { ST_IDLE, ST_CALC, ST_OUT } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/flit_checksum_unit_fold.sv
// Combinational fold of one group of chunks (chunk 0 in the MSB slot) into the
// running checksum accumulator, either XOR or ones'-complement with end-around carry.
module checksum_fold_comb
    import flit_checksum_unit_pkg::*;
#(
    parameter int         CSUM_W           = DEF_CSUM_W,
    parameter int         CHUNKS_PER_CYCLE = 2,
    parameter csum_algo_e ALGO             = CSUM_ONES
) (
    input  logic [CSUM_W-1:0]                  acc,
    input  logic [CHUNKS_PER_CYCLE*CSUM_W-1:0] chunks,
    output logic [CSUM_W-1:0]                  acc_next
);

    logic [CSUM_W-1:0] chunk;
    logic [CSUM_W:0]   sum;

    // Each chunk's carry-out is wrapped back into the LSB before the next chunk is added.
    always_comb begin
        acc_next = acc;
        chunk    = '0;
        sum      = '0;
        for (int i = 0; i < CHUNKS_PER_CYCLE; i++) begin
            chunk = chunks[(CHUNKS_PER_CYCLE-1-i)*CSUM_W +: CSUM_W];
            if (ALGO == CSUM_XOR) begin
                acc_next = acc_next ^ chunk;
            end else begin
                sum      = {1'b0, acc_next} + {1'b0, chunk};
                acc_next = sum[CSUM_W-1:0] + CSUM_W'(sum[CSUM_W]);
            end
        end
    end

endmodule

// File: rtl/flit_checksum_unit.sv
// Sequential flit checksum engine: generates (GEN) or verifies (CHK) the trailing
// checksum over a valid/ready link, with optional drop of corrupt flits and an error counter.
module flit_checksum_unit
    import flit_checksum_unit_pkg::*;
#(
    parameter int         HEADER_W         = DEF_HEADER_W,
    parameter int         PAYLOAD_W        = DEF_PAYLOAD_W,
    parameter int         CSUM_W           = DEF_CSUM_W,
    parameter int         CHUNKS_PER_CYCLE = 2,
    parameter csum_algo_e ALGO             = CSUM_ONES,
    parameter bit         DROP_BAD         = 1'b1,
    parameter int         ERR_CNT_W        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 mode_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [HEADER_W+PAYLOAD_W+CSUM_W-1:0] in_flit_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [HEADER_W+PAYLOAD_W+CSUM_W-1:0] out_flit_o,
    output logic                                 out_err_o,
    output logic                                 err_pulse_o,
    output logic [ERR_CNT_W-1:0]                 err_cnt_o,
    input  logic                                 err_clr_i
);

    localparam int DATA_W  = HEADER_W + PAYLOAD_W;
    localparam int FLIT_W  = DATA_W + CSUM_W;
    localparam int NCHUNK  = ceil_div(DATA_W, CSUM_W);
    localparam int N_ITER  = ceil_div(NCHUNK, CHUNKS_PER_CYCLE);
    localparam int PAD_W   = NCHUNK * CSUM_W;
    localparam int GROUP_W = CHUNKS_PER_CYCLE * CSUM_W;
    localparam int SLOT_W  = N_ITER * GROUP_W;
    localparam int ITER_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

    state_e               state;
    state_e               state_next;
    mode_e                mode_q;
    logic [DATA_W-1:0]    data_q;
    logic [CSUM_W-1:0]    rx_csum_q;
    logic [CSUM_W-1:0]    csum_q;
    logic [CSUM_W-1:0]    acc;
    logic [CSUM_W-1:0]    acc_next;
    logic [CSUM_W-1:0]    csum_final;
    logic [PAD_W-1:0]     pad_in;
    logic [SLOT_W-1:0]    slots_in;
    logic [SLOT_W-1:0]    work;
    logic [ITER_W-1:0]    iter;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 err_q;
    logic                 err_pulse_q;
    logic                 mismatch;
    logic                 last_iter;
    logic                 accept_in;

    // Zero-pad the data at the MSB end to whole chunks, then append empty chunk slots
    // at the LSB end so the final group is always full width.
    always_comb begin
        pad_in             = '0;
        pad_in[DATA_W-1:0] = in_flit_i[FLIT_W-1:CSUM_W];
        slots_in           = '0;
        slots_in[SLOT_W-1 -: PAD_W] = pad_in;
    end

    checksum_fold_comb #(
        .CSUM_W          (CSUM_W),
        .CHUNKS_PER_CYCLE(CHUNKS_PER_CYCLE),
        .ALGO            (ALGO)
    ) u_fold (
        .acc     (acc),
        .chunks  (work[SLOT_W-1 -: GROUP_W]),
        .acc_next(acc_next)
    );

    assign csum_final = (ALGO == CSUM_ONES) ? ~acc_next : acc_next;
    assign mismatch   = (mode_q == MODE_CHK) && (csum_final != rx_csum_q);
    assign last_iter  = (iter == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        accept_in   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept_in  = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_iter) begin
                    state_next = (mismatch && DROP_BAD) ? ST_IDLE : ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The pulse is raised on the last CALC edge, so it lines up with the first OUT
    // cycle when forwarding and with the return to IDLE when dropping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            rx_csum_q   <= '0;
            csum_q      <= '0;
            acc         <= '0;
            work        <= '0;
            iter        <= '0;
            mode_q      <= MODE_GEN;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (accept_in) begin
                data_q    <= in_flit_i[FLIT_W-1:CSUM_W];
                rx_csum_q <= in_flit_i[CSUM_W-1:0];
                mode_q    <= mode_e'(mode_i);
                acc       <= '0;
                iter      <= '0;
                work      <= slots_in;
            end else if (state == ST_CALC) begin
                acc  <= acc_next;
                iter <= iter + 1'b1;
                work <= work << GROUP_W;
                if (last_iter) begin
                    csum_q      <= csum_final;
                    err_q       <= mismatch;
                    err_pulse_q <= mismatch;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_clr_i) begin
            err_cnt_q <= '0;
        end else if (err_pulse_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign out_flit_o  = {data_q, csum_q};
    assign out_err_o   = out_valid_o & err_q;
    assign err_pulse_o = err_pulse_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_flit_checksum_unit.sv
// Bench for flit_checksum_unit: a ones'-complement forwarding instance and an XOR
// dropping instance with a narrow counter, checked against constants and a scoreboard.
module tb_flit_checksum_unit;
    import flit_checksum_unit_pkg::*;

    typedef struct {
        logic [63:0] flit;
        logic        err;
    } exp_t;

    typedef struct {
        int          d;
        bit          mode;
        flit_t       flit;
        checksum_t   exp_csum;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode      [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    flit_t       in_flit   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    flit_t       out_flit  [2];
    logic        out_err   [2];
    logic        err_pulse [2];
    logic        err_clr   [2];
    logic [15:0] err_cnt   [2];
    logic [15:0] err_cnt0_raw;
    logic [2:0]  err_cnt1_raw;

    int   n_vec = 0;
    int   n_fail = 0;
    int   exp_cnt [2];
    int   exp_pulses [2];
    int   seen_pulses [2] = '{0, 0};
    exp_t sbq0 [$];
    exp_t sbq1 [$];
    vec_t vecs [13];

    int        rd;
    bit        rm;
    flit_t     rf;
    checksum_t rc;
    bit        re;

    always #5 clk = ~clk;

    assign err_cnt[0] = err_cnt0_raw;
    assign err_cnt[1] = 16'(err_cnt1_raw);

    flit_checksum_unit #(.ALGO(CSUM_ONES), .DROP_BAD(1'b0)) u_dut_ones (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_i     (mode[0]),
        .in_valid_i (in_valid[0]),
        .in_ready_o (in_ready[0]),
        .in_flit_i  (in_flit[0]),
        .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]),
        .out_flit_o (out_flit[0]),
        .out_err_o  (out_err[0]),
        .err_pulse_o(err_pulse[0]),
        .err_cnt_o  (err_cnt0_raw),
        .err_clr_i  (err_clr[0])
    );

    flit_checksum_unit #(.ALGO(CSUM_XOR), .DROP_BAD(1'b1), .ERR_CNT_W(3)) u_dut_xor (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_i     (mode[1]),
        .in_valid_i (in_valid[1]),
        .in_ready_o (in_ready[1]),
        .in_flit_i  (in_flit[1]),
        .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]),
        .out_flit_o (out_flit[1]),
        .out_err_o  (out_err[1]),
        .err_pulse_o(err_pulse[1]),
        .err_cnt_o  (err_cnt1_raw),
        .err_clr_i  (err_clr[1])
    );

    // Reference checksum: plain integer sum folded at the end, rather than per-chunk carries.
    function automatic checksum_t model_csum(input logic [55:0] data, input bit ones);
        int unsigned total;
        checksum_t   x;
        checksum_t   c;
        logic [31:0] t;
        total = 0;
        x     = '0;
        for (int i = 0; i < 7; i++) begin
            c     = data[8*i +: 8];
            x     = x ^ c;
            total = total + 32'(c);
        end
        if (!ones) return x;
        while (total > 255) total = (total & 255) + (total >> 8);
        t = total;
        return ~t[7:0];
    endfunction

    function automatic int maxCnt(input int d);
        return (d == 0) ? 65535 : 7;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic noteTimeout(input string name);
        n_vec++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic checkCount(input int d);
        checkOutput($sformatf("dut%0d err_cnt", d), 64'(err_cnt[d]), 64'(exp_cnt[d]));
    endtask

    task automatic applyStimulus(input int d, input bit m, input flit_t f,
                                 input checksum_t ec, input bit ee);
        exp_t e;
        int   guard;
        guard = 0;
        while (in_ready[d] !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (in_ready[d] !== 1'b1) begin
            noteTimeout($sformatf("dut%0d in_ready", d));
            return;
        end
        in_valid[d] = 1'b1;
        in_flit[d]  = f;
        mode[d]     = m;
        e.flit = {f[63:8], ec};
        e.err  = ee;
        if (!(ee && d == 1)) begin
            if (d == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
        end
        if (ee) begin
            exp_pulses[d]++;
            if (exp_cnt[d] < maxCnt(d)) exp_cnt[d]++;
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        mode[d]     = ~m;
        in_flit[d]  = ~f;
    endtask

    task automatic waitDone(input int d);
        int guard;
        guard = 0;
        while (in_ready[d] !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (in_ready[d] !== 1'b1) noteTimeout($sformatf("dut%0d idle", d));
        @(posedge clk); #1;
    endtask

    task automatic popAndCheck(input int d);
        exp_t e;
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL dut%0d unexpected output: got %h, expected none", d, out_flit[d]);
            return;
        end
        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
        checkOutput($sformatf("dut%0d out_flit", d), out_flit[d], e.flit);
        checkOutput($sformatf("dut%0d out_err", d), 64'(out_err[d]), 64'(e.err));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (err_pulse[d] === 1'b1) seen_pulses[d]++;
                if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) popAndCheck(d);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1, 1'b0, {16'h0001, 40'h0000000002, 8'h55}, 8'h03, 1'b0};
        vecs[1]  = '{0, 1'b0, {16'h0001, 40'h0000000002, 8'h55}, 8'hFC, 1'b0};
        vecs[2]  = '{0, 1'b0, {16'hFFFF, 40'hFFFFFFFFFF, 8'h12}, 8'h00, 1'b0};
        vecs[3]  = '{0, 1'b1, {16'h0001, 40'h0000000002, 8'hFC}, 8'hFC, 1'b0};
        vecs[4]  = '{0, 1'b1, {16'h0001, 40'h0000000002, 8'hFD}, 8'hFC, 1'b1};
        vecs[5]  = '{1, 1'b1, {16'h0001, 40'h0000000002, 8'h03}, 8'h03, 1'b0};
        vecs[6]  = '{0, 1'b0, {16'h1234, 40'h56789ABCDE, 8'h00}, 8'hB4, 1'b0};
        vecs[7]  = '{1, 1'b0, {16'h1234, 40'h56789ABCDE, 8'h00}, 8'hF0, 1'b0};
        vecs[8]  = '{1, 1'b1, {16'h1234, 40'h56789ABCDE, 8'hF0}, 8'hF0, 1'b0};
        vecs[9]  = '{0, 1'b1, {16'h1234, 40'h56789ABCDE, 8'hB4}, 8'hB4, 1'b0};
        vecs[10] = '{1, 1'b0, {16'hFFFF, 40'hFFFFFFFFFF, 8'h00}, 8'hFF, 1'b0};
        vecs[11] = '{1, 1'b0, {16'h0000, 40'h0000000000, 8'hAA}, 8'h00, 1'b0};
        vecs[12] = '{0, 1'b0, {16'h0000, 40'h0000000000, 8'hAA}, 8'hFF, 1'b0};

        for (int d = 0; d < 2; d++) begin
            mode[d]       = 1'b0;
            in_valid[d]   = 1'b0;
            in_flit[d]    = '0;
            out_ready[d]  = 1'b1;
            err_clr[d]    = 1'b0;
            exp_cnt[d]    = 0;
            exp_pulses[d] = 0;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(in_ready[0]), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid[0]), 64'd0);
        checkOutput("reset out_flit", out_flit[0], 64'd0);
        checkOutput("reset out_err", 64'(out_err[0]), 64'd0);
        checkOutput("reset err_pulse", 64'(err_pulse[0]), 64'd0);
        checkOutput("reset err_cnt", 64'(err_cnt[0]), 64'd0);
        checkOutput("reset dut1 in_ready", 64'(in_ready[1]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and forwarded error on the ones'-complement instance.
        applyStimulus(0, 1'b1, {16'h0001, 40'h0000000002, 8'hFD}, 8'hFC, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("calc cycle %0d out_valid", k), 64'(out_valid[0]), 64'd0);
            checkOutput($sformatf("calc cycle %0d in_ready", k), 64'(in_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        checkOutput("first out cycle out_valid", 64'(out_valid[0]), 64'd1);
        checkOutput("first out cycle err_pulse", 64'(err_pulse[0]), 64'd1);
        checkOutput("first out cycle out_err", 64'(out_err[0]), 64'd1);
        @(posedge clk); #1;
        checkOutput("after accept out_valid", 64'(out_valid[0]), 64'd0);
        checkOutput("after accept in_ready", 64'(in_ready[0]), 64'd1);
        checkOutput("pulse one cycle", 64'(err_pulse[0]), 64'd0);
        checkCount(0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].d, vecs[i].mode, vecs[i].flit, vecs[i].exp_csum, vecs[i].exp_err);
            waitDone(vecs[i].d);
            checkCount(vecs[i].d);
        end

        // Dropped bad flit followed by a good one on the XOR instance.
        applyStimulus(1, 1'b1, {16'h0002, 40'h0000000002, 8'h55}, 8'h00, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("drop in_ready back", 64'(in_ready[1]), 64'd1);
        checkOutput("drop no out_valid", 64'(out_valid[1]), 64'd0);
        checkOutput("drop err_pulse", 64'(err_pulse[1]), 64'd1);
        applyStimulus(1, 1'b1, {16'h0001, 40'h0000000002, 8'h03}, 8'h03, 1'b0);
        waitDone(1);
        checkCount(1);

        // Backpressure: output must hold steady while downstream stalls.
        out_ready[0] = 1'b0;
        applyStimulus(0, 1'b0, {16'hBEEF, 40'h0123456789, 8'h00}, 8'hF6, 1'b0);
        begin
            int guard;
            guard = 0;
            while (out_valid[0] !== 1'b1 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (out_valid[0] !== 1'b1) noteTimeout("backpressure out_valid");
        end
        for (int k = 0; k < 10; k++) begin
            checkOutput("stall out_flit", out_flit[0], {16'hBEEF, 40'h0123456789, 8'hF6});
            checkOutput("stall in_ready", 64'(in_ready[0]), 64'd0);
            checkOutput("stall out_valid", 64'(out_valid[0]), 64'd1);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("release out_valid", 64'(out_valid[0]), 64'd0);
        checkOutput("release in_ready", 64'(in_ready[0]), 64'd1);

        for (int i = 0; i < 12; i++) begin
            rd = i % 2;
            rm = 1'($urandom_range(0, 1));
            rf = {$urandom, $urandom};
            rc = model_csum(rf[63:8], rd == 0);
            if (rm && ($urandom_range(0, 1) == 1)) rf[7:0] = rc;
            re = rm && (rc != rf[7:0]);
            applyStimulus(rd, rm, rf, rc, re);
            waitDone(rd);
            checkCount(rd);
        end

        // Drive the 3-bit counter into saturation and beyond.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1'b1, {16'h0002, 40'h0000000002, 8'h55}, 8'h00, 1'b1);
            waitDone(1);
            checkCount(1);
        end

        applyStimulus(1, 1'b1, {16'h0002, 40'h0000000002, 8'h55}, 8'h00, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("clr collision err_pulse", 64'(err_pulse[1]), 64'd1);
        err_clr[1] = 1'b1;
        @(posedge clk); #1;
        err_clr[1] = 1'b0;
        exp_cnt[1] = 0;
        checkCount(1);
        checkOutput("clr collision pulse gone", 64'(err_pulse[1]), 64'd0);

        // Reset in the middle of CALC loses the in-flight flit.
        applyStimulus(0, 1'b0, {16'hCAFE, 40'h0000000001, 8'h00}, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc reset out_valid", 64'(out_valid[0]), 64'd0);
        checkOutput("midcalc reset in_ready", 64'(in_ready[0]), 64'd1);
        checkOutput("midcalc reset err_cnt", 64'(err_cnt[0]), 64'd0);
        void'(sbq0.pop_back());
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, {16'h0001, 40'h0000000002, 8'h00}, 8'hFC, 1'b0);
        waitDone(0);
        checkCount(0);
        checkCount(1);

        checkOutput("dut0 scoreboard drained", 64'(sbq0.size()), 64'd0);
        checkOutput("dut1 scoreboard drained", 64'(sbq1.size()), 64'd0);
        checkOutput("dut0 pulse total", 64'(seen_pulses[0]), 64'(exp_pulses[0]));
        checkOutput("dut1 pulse total", 64'(seen_pulses[1]), 64'(exp_pulses[1]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
